// File: rtl/bus_arbiter_n_if.sv
// Shared-bus arbiter bundle: master request/data lines in, one-hot ack and muxed bus out.
interface bus_arbiter_n_if #(
   parameter int NUM_MASTERS = 8,
   parameter int GRANT_W     = 3,
   parameter int CWIDTH      = 4,
   parameter int DWIDTH      = 32
);
   logic [NUM_MASTERS-1:0]        req;
   logic [NUM_MASTERS-1:0]        ack;
   logic [NUM_MASTERS*CWIDTH-1:0] ctrl_in;
   logic [NUM_MASTERS*DWIDTH-1:0] data_in;
   logic [CWIDTH-1:0]             bus_ctrl;
   logic [DWIDTH-1:0]             bus_data;
   logic                          bus_busy;
   logic [GRANT_W-1:0]            grant_id;
   logic                          timeout;

   modport master (output req, ctrl_in, data_in,
                   input  ack, bus_ctrl, bus_data, bus_busy, grant_id, timeout);
   modport slave  (input  req, ctrl_in, data_in,
                   output ack, bus_ctrl, bus_data, bus_busy, grant_id, timeout);
endinterface

// File: rtl/bus_arbiter_n.sv
// N-master shared-bus arbiter, fixed-priority or round-robin, with a mandatory TURN gap.
// Optional hold-time watchdog enabled by defining BUS_ARB_WATCHDOG_EN.
module bus_arbiter_n #(
   parameter int NUM_MASTERS = 8,
   parameter int GRANT_W     = 3,
   parameter int CWIDTH      = 4,
   parameter int DWIDTH      = 32,
   parameter int ARB_MODE    = 0,
   parameter int HOLD_MAX    = 64
) (
   input  logic            i_clk,
   input  logic            i_reset,
   bus_arbiter_n_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

   if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || (2**GRANT_W) < NUM_MASTERS ||
       ARB_MODE < 0 || ARB_MODE > 1 || HOLD_MAX < 2) begin : g_param_err
      $error("bus_arbiter_n: illegal parameter set");
   end

   state_t                 r_state;
   logic [NUM_MASTERS-1:0] r_ack;
   logic                   r_busy;
   logic [GRANT_W-1:0]     r_gid;

   logic [NUM_MASTERS-1:0] w_elig;
   logic [GRANT_W-1:0]     w_win;
   logic                   w_any;
   int                     w_start;
   int                     w_idx;

`ifdef BUS_ARB_WATCHDOG_EN
   localparam int CNT_W = $clog2(HOLD_MAX + 1);
   logic [CNT_W-1:0]       r_cnt;
   logic [NUM_MASTERS-1:0] r_mask;
   logic                   r_timeout;

   assign w_elig      = bus.req & ~r_mask;
   assign bus.timeout = r_timeout;
`else
   assign w_elig      = bus.req;
   assign bus.timeout = 1'b0;
`endif

   // Round robin searches upward from the master after the last grantee, wrapping.
   always_comb begin
      w_any   = |w_elig;
      w_win   = '0;
      w_start = (int'(r_gid) >= NUM_MASTERS - 1) ? 0 : int'(r_gid) + 1;
      w_idx   = 0;
      if (ARB_MODE == 0) begin
         for (int i = 0; i < NUM_MASTERS; i++)
            if (w_elig[i]) w_win = GRANT_W'(i);
      end else begin
         for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            w_idx = w_start + k;
            if (w_idx >= NUM_MASTERS) w_idx = w_idx - NUM_MASTERS;
            if (w_elig[w_idx]) w_win = GRANT_W'(w_idx);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state   <= IDLE;
         r_ack     <= '0;
         r_busy    <= 1'b0;
         r_gid     <= GRANT_W'(NUM_MASTERS - 1);
`ifdef BUS_ARB_WATCHDOG_EN
         r_cnt     <= '0;
         r_mask    <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
`ifdef BUS_ARB_WATCHDOG_EN
         r_timeout <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
`ifdef BUS_ARB_WATCHDOG_EN
               r_mask <= '0;
               r_cnt  <= '0;
`endif
               if (w_any) begin
                  r_ack   <= ONE << w_win;
                  r_gid   <= w_win;
                  r_busy  <= 1'b1;
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               if (!bus.req[r_gid]) begin
                  r_ack   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= TURN;
               end
`ifdef BUS_ARB_WATCHDOG_EN
               // Overlong hold: revoke and keep this master out of the next arbitration.
               else if (r_cnt == CNT_W'(HOLD_MAX - 1)) begin
                  r_ack     <= '0;
                  r_busy    <= 1'b0;
                  r_timeout <= 1'b1;
                  r_mask    <= ONE << r_gid;
                  r_state   <= TURN;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            TURN:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ack      = r_ack;
   assign bus.bus_busy = r_busy;
   assign bus.grant_id = r_gid;
   assign bus.bus_ctrl = r_busy ? bus.ctrl_in[r_gid*CWIDTH +: CWIDTH] : '0;
   assign bus.bus_data = r_busy ? bus.data_in[r_gid*DWIDTH +: DWIDTH] : '0;
endmodule

// File: tb/tb_bus_arbiter_n.sv
// Random + directed bench for bus_arbiter_n: one fixed-priority and one round-robin instance.
module tb_bus_arbiter_n;
   localparam int N    = 8;
   localparam int CW   = 4;
   localparam int DW   = 32;
   localparam int HOLD = 4;
`ifdef BUS_ARB_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*CW-1:0] ctrl_in = '0;
   logic [N*DW-1:0] data_in = '0;

   int n_chk = 0;
   int n_err = 0;

   // model state, index 0 = fixed priority, 1 = round robin
   int m_own[2], m_last[2], m_cool[2], m_held[2], m_mask[2], m_to[2];

   always #5 clk = ~clk;

   bus_arbiter_n_if #(.NUM_MASTERS(N), .GRANT_W(3), .CWIDTH(CW), .DWIDTH(DW)) if_fp ();
   bus_arbiter_n_if #(.NUM_MASTERS(N), .GRANT_W(3), .CWIDTH(CW), .DWIDTH(DW)) if_rr ();

   assign if_fp.req = req;  assign if_fp.ctrl_in = ctrl_in;  assign if_fp.data_in = data_in;
   assign if_rr.req = req;  assign if_rr.ctrl_in = ctrl_in;  assign if_rr.data_in = data_in;

   bus_arbiter_n #(.NUM_MASTERS(N), .GRANT_W(3), .CWIDTH(CW), .DWIDTH(DW),
                   .ARB_MODE(0), .HOLD_MAX(HOLD)) u_fp (.i_clk(clk), .i_reset(reset), .bus(if_fp));
   bus_arbiter_n #(.NUM_MASTERS(N), .GRANT_W(3), .CWIDTH(CW), .DWIDTH(DW),
                   .ARB_MODE(1), .HOLD_MAX(HOLD)) u_rr (.i_clk(clk), .i_reset(reset), .bus(if_rr));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int oh2idx(input logic [N-1:0] v);
      int r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Behavioural view: an owner holds the bus until it lets go (or overstays),
   // then one dead cycle, then the best eligible requester takes it.
   task automatic model_step(input int d);
      int pick, idx;
      if (!reset) begin
         m_own[d] = -1; m_last[d] = N - 1; m_cool[d] = 0;
         m_held[d] = 0; m_mask[d] = -1;   m_to[d]   = 0;
         return;
      end
      m_to[d] = 0;
      if (m_own[d] >= 0) begin
         if (!req[m_own[d]]) begin
            m_own[d] = -1; m_cool[d] = 1;
         end else if (WD && m_held[d] == HOLD - 1) begin
            m_mask[d] = m_own[d]; m_own[d] = -1; m_cool[d] = 1; m_to[d] = 1;
         end else m_held[d]++;
      end else if (m_cool[d] > 0) begin
         m_cool[d]--;
      end else begin
         pick = -1;
         for (int k = 1; k <= N; k++) begin
            idx = (d == 0) ? N - k : (m_last[d] + k) % N;
            if (pick < 0 && req[idx] && idx != m_mask[d]) pick = idx;
         end
         m_mask[d] = -1;
         if (pick >= 0) begin
            m_own[d] = pick; m_last[d] = pick; m_held[d] = 0;
         end
      end
   endtask

   task automatic check_one(input int d, input logic [N-1:0] a, input logic b,
                            input logic [2:0] g, input logic t,
                            input logic [CW-1:0] c, input logic [DW-1:0] dt);
      logic [N-1:0]  ea = '0;
      logic [CW-1:0] ec = '0;
      logic [DW-1:0] ed = '0;
      if (m_own[d] >= 0) begin
         ea[m_own[d]] = 1'b1;
         ec = ctrl_in[m_own[d]*CW +: CW];
         ed = data_in[m_own[d]*DW +: DW];
      end
      chk($sformatf("d%0d_ack", d),  a, ea);
      chk($sformatf("d%0d_busy", d), b, m_own[d] >= 0);
      chk($sformatf("d%0d_gid", d),  g, m_last[d]);
      chk($sformatf("d%0d_tout", d), t, m_to[d]);
      chk($sformatf("d%0d_ctrl", d), c, ec);
      chk($sformatf("d%0d_data", d), dt, ed);
   endtask

   task automatic cycle(input logic [N-1:0] rq, input logic rst_n, input bit rnd);
      req   = rq;
      reset = rst_n;
      for (int i = 0; i < N; i++) begin
         data_in[i*DW +: DW] = rnd ? DW'($urandom) : 32'hDEADBEEF;
         ctrl_in[i*CW +: CW] = rnd ? CW'($urandom) : 4'hA;
      end
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_one(0, if_fp.ack, if_fp.bus_busy, if_fp.grant_id, if_fp.timeout,
                if_fp.bus_ctrl, if_fp.bus_data);
      check_one(1, if_rr.ack, if_rr.bus_busy, if_rr.grant_id, if_rr.timeout,
                if_rr.bus_ctrl, if_rr.bus_data);
   endtask

   initial begin
      logic [N-1:0] rq;
      logic [N-1:0] prev;
      int held, gap, n_to, seen1;
      int order[$];
      int exp_order[5] = '{0, 1, 2, 3, 0};

      for (int d = 0; d < 2; d++) begin
         m_own[d] = -1; m_last[d] = N - 1; m_cool[d] = 0;
         m_held[d] = 0; m_mask[d] = -1;   m_to[d] = 0;
      end

      // reset with every master requesting
      repeat (3) cycle(8'hFF, 1'b0, 1'b1);
      chk("rst_ack", if_fp.ack, 8'h00);
      chk("rst_gid", if_rr.grant_id, 3'd7);

      // fixed priority: 7 beats 0, then 0 after release + TURN
      cycle(8'h81, 1'b1, 1'b1);
      chk("fp_first", if_fp.ack, 8'h80);
      cycle(8'h81, 1'b1, 1'b1);
      cycle(8'h01, 1'b1, 1'b1);
      chk("fp_release", if_fp.ack, 8'h00);
      cycle(8'h01, 1'b1, 1'b1);
      chk("fp_turn", if_fp.ack, 8'h00);
      cycle(8'h01, 1'b1, 1'b1);
      chk("fp_second", if_fp.ack, 8'h01);

      // idle mux with a recognisable data pattern
      repeat (4) cycle(8'h00, 1'b1, 1'b0);
      chk("idle_data", if_fp.bus_data, 32'h0);
      chk("idle_ctrl", if_rr.bus_ctrl, 4'h0);

      // round robin: each master holds two cycles then drops
      repeat (2) cycle(8'h0F, 1'b0, 1'b1);
      prev = '0; held = 0; gap = 0;
      for (int c = 0; c < 60 && order.size() < 5; c++) begin
         rq = 8'h0F;
         if (if_rr.ack != 0 && held >= 2) rq = 8'h0F & ~if_rr.ack;
         cycle(rq, 1'b1, 1'b1);
         if (if_rr.ack != 0) begin
            if (prev == 0) begin
               order.push_back(oh2idx(if_rr.ack));
               if (order.size() > 1) chk("rr_gap", gap, 2);
               held = 1;
            end else held++;
            gap = 0;
         end else gap++;
         prev = if_rr.ack;
      end
      chk("rr_count", order.size(), 5);
      for (int i = 0; i < 5 && i < order.size(); i++)
         chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);

      // reset while master 3 owns the bus
      repeat (3) cycle(8'h08, 1'b1, 1'b1);
      chk("mid_pre", if_rr.ack, 8'h08);
      cycle(8'h08, 1'b0, 1'b1);
      chk("mid_ack", if_rr.ack, 8'h00);
      chk("mid_gid", if_rr.grant_id, 3'd7);
      cycle(8'h2C, 1'b1, 1'b1);
      chk("mid_rr_low", if_rr.grant_id, 3'd2);

      // long hold: watchdog behaviour depends on the build
      repeat (2) cycle(8'h06, 1'b0, 1'b1);
      n_to = 0; seen1 = 0;
      for (int c = 0; c < 120; c++) begin
         cycle(8'h06, 1'b1, 1'b1);
         if (if_fp.timeout) n_to++;
         if (if_fp.ack == 8'h02) seen1 = 1;
      end
      if (WD) begin
         chk("wd_timeout", n_to > 0, 1'b1);
         chk("wd_m1", seen1, 1);
      end else begin
         chk("nowd_timeout", n_to, 0);
         chk("nowd_hold", if_fp.ack, 8'h04);
      end

      // random traffic with sticky requests and occasional reset
      rq = '0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(3) == 0) rq[$urandom_range(N-1)] ^= 1'b1;
         if ($urandom_range(15) == 0) rq = '0;
         cycle(rq, ($urandom_range(149) != 0), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
- Parametrised shared-bus arbiter for N bus masters: the CPU, DMA and debug masters.
- Accepts one request line per master and returns a registered one-hot ack.
- Muxes the granted master's ctrl/data onto the shared bus.
- Generalises the fixed CPU-on-req[7] wiring to any master count, with selectable fixed-priority or round-robin mode and a hold-time watchdog.

Parameters:
- NUM_MASTERS, 8, number of masters; legal range 2..16.
- GRANT_W, 3, width of grant_id; must satisfy 2**GRANT_W >= NUM_MASTERS.
- CWIDTH, 4, bus control width.
- DWIDTH, 32, bus data width.
- ARB_MODE, 0, 0 = fixed priority (highest index wins), 1 = round robin.
- HOLD_MAX, 64, maximum grant length in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  NUM_MASTERS  per-master bus request, level-sensitive.
- ack  out  NUM_MASTERS  one-hot registered grant.
- ctrl_in  in  NUM_MASTERS*CWIDTH  flattened master control; master i occupies bits [i*CWIDTH +: CWIDTH].
- data_in  in  NUM_MASTERS*DWIDTH  flattened master data; master i occupies bits [i*DWIDTH +: DWIDTH].
- bus_ctrl  out  CWIDTH  shared bus control.
- bus_data  out  DWIDTH  shared bus data.
- bus_busy  out  1  high while any grant is active.
- grant_id  out  GRANT_W  index of the current or most recent grantee.
- timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset (reset == 0 at a rising edge):
  - ack = 0, bus_busy = 0, grant_id = NUM_MASTERS-1, timeout = 0.
  - Hold counter = 0, mask = 0, state = IDLE.
  - Reset takes priority over everything and revokes any active grant on that edge.
- FSM states: IDLE, GRANT, TURN.
- IDLE:
  - If (req & ~mask) != 0, select winner w.
  - Next edge: ack = 1 << w, grant_id = w, bus_busy = 1, state = GRANT, mask cleared.
  - Latency: req sampled at edge k gives ack visible after edge k+1, i.e. one cycle.
  - If no eligible request, stay in IDLE.
- Winner selection:
  - ARB_MODE 0: highest set index of (req & ~mask).
  - ARB_MODE 1: first set index searching upward from (grant_id+1) mod NUM_MASTERS, wrapping. With the reset value of grant_id, the first search starts at index 0.
- GRANT:
  - ack held while req[grant_id] = 1; other requests are ignored, no preemption.
  - When req[grant_id] is sampled 0: next edge ack = 0, bus_busy = 0, state = TURN.
- TURN:
  - One mandatory idle bus cycle, then IDLE.
  - Minimum gap between two grants is 2 cycles: the release edge plus the TURN edge.
  - Requests present during TURN are arbitrated in the following IDLE cycle.
- Bus mux (combinational from registered state):
  - bus_ctrl/bus_data = the granted master's slice when bus_busy = 1, otherwise all zeros.
- Simultaneous events:
  - A master dropping req in the same cycle another raises it: release is processed first; the new master wins only after TURN.
  - A request pulse shorter than one sampled cycle in IDLE is lost; no request latching.
- grant_id keeps the last grantee through TURN and IDLE; round robin depends on this.
- Out-of-range indices (NUM_MASTERS..2**GRANT_W-1) are never granted.

Optional Feature:
- Macro BUS_ARB_WATCHDOG_EN.
- Defined:
  - A counter increments each GRANT cycle.
  - When it reaches HOLD_MAX-1 with req still high, the next edge forces ack = 0, bus_busy = 0, timeout = 1 for one cycle, and state = TURN.
  - mask = 1 << grant_id for the next arbitration only. A masked master may win again if it is the only requester after that arbitration clears the mask.
  - The counter clears on entry to GRANT.
- Not defined:
  - No counter or mask logic is synthesised.
  - timeout is tied 0; grants last indefinitely.

Test Plan:
- Reset: reset = 0 for 3 cycles with req = 8'hFF -> ack = 0, bus_busy = 0, grant_id = 7, bus_data = 0 throughout.
- Fixed priority (ARB_MODE 0): req = 8'h81 at cycle 0 -> ack = 8'h80 at cycle 1; bus_data = data_in slice 7. Drop req[7] -> ack = 0 one cycle later, TURN, then ack = 8'h01 two cycles after release.
- Round robin (ARB_MODE 1): req = 8'h0F held, each master drops req after 2 granted cycles -> grant order 0, 1, 2, 3, 0, with a 2-cycle gap between grants.
- Idle mux: no requests with data_in all 32'hDEADBEEF -> bus_data = 0, bus_ctrl = 0.
- Reset mid-grant: master 3 granted, reset = 0 for 1 cycle -> ack = 0 on that edge, grant_id = 7. First grant after release (ARB_MODE 1) goes to the lowest requester.
- Watchdog (BUS_ARB_WATCHDOG_EN, HOLD_MAX = 4): req = 8'h06 held -> master 2 acked for 4 cycles, then timeout pulse. After TURN, master 1 is granted even in ARB_MODE 0. Without the macro, master 2 holds the grant for more than 100 cycles and timeout stays 0.
